// File: rtl/tb_gen_pkg.sv
// Shared definitions for the stimulus sequencer: FSM states, mode codes and the LFSR rule.
package tb_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic MODE_DIR = 1'b0;
  localparam logic MODE_RND = 1'b1;

  // Taps at bits 15, 13, 12 and 10: x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One Fibonacci step: shift left and feed the tap parity into bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

  // An all-zero LFSR state would lock up, so a zero seed becomes 1
  function automatic logic [15:0] seed_fix(input logic [15:0] s);
    return (s == 16'd0) ? 16'd1 : s;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reload and single-step enable.
module lfsr16
  import tb_gen_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = 16'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  // Reload takes priority over stepping; otherwise hold the current state
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed;
    end else if (step) begin
      q_d = lfsr_next(q_q);
    end
  end

  // State register, reset to the configured seed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tb_stim_sequencer.sv
// Cycle-accurate stimulus sequencer: walks a directed or LFSR sequence, holding each vector.
module tb_stim_sequencer
  import tb_gen_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 10,
  parameter int SEED        = 5,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             pause,
  output logic [WIDTH-1:0] stim,
  output logic [CNT_W-1:0] seq,
  output logic             stim_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [15:0] SEED_EFF  = seed_fix(16'(SEED));
  localparam int          HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [WIDTH-1:0]   stim_q, stim_d;
  logic [CNT_W-1:0]   seq_q, seq_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               lfsr_load;
  logic               lfsr_step;
  logic [15:0]        lfsr_q;

  lfsr16 #(.RESET_VAL(SEED_EFF)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (lfsr_load),
    .seed (SEED_EFF),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  // Next-state logic: start handling, hold counting, vector updates and completion
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    rem_d     = rem_q;
    hold_d    = hold_q;
    stim_d    = stim_q;
    seq_d     = seq_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          rem_d   = repeat_cnt;
          seq_d   = '0;
          hold_d  = '0;
          valid_d = 1'b1;
          if (mode == MODE_RND) begin
            lfsr_load = 1'b1;
            stim_d    = SEED_EFF[WIDTH-1:0];
          end else begin
            stim_d = '0;
          end
          state_d = (repeat_cnt == '0) ? DRAIN : RUN;
        end
      end

      RUN: begin
        if (!pause) begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            seq_d   = seq_q + CNT_W'(1);
            rem_d   = rem_q - CNT_W'(1);
            valid_d = 1'b1;
            if (mode_q == MODE_RND) begin
              lfsr_step = 1'b1;
              stim_d    = WIDTH'(lfsr_next(lfsr_q));
            end else begin
              stim_d = stim_q + WIDTH'(1);
            end
            if (rem_q == CNT_W'(1)) begin
              state_d = DRAIN;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end

      DRAIN: begin
        if (!pause) begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered state and outputs; reset abandons any run without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_DIR;
      rem_q   <= '0;
      hold_q  <= '0;
      stim_q  <= '0;
      seq_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      hold_q  <= hold_d;
      stim_q  <= stim_d;
      seq_q   <= seq_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign stim       = stim_q;
  assign seq        = seq_q;
  assign stim_valid = valid_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_tb_stim_sequencer.sv
// Scoreboard bench for tb_stim_sequencer: a cycle-level model predicts every stim_valid/done event.
module tb_tb_stim_sequencer;

  localparam int WIDTH = 8;
  localparam int HOLD  = 10;
  localparam int SEED  = 5;
  localparam int CNT_W = 16;

  typedef struct {
    bit               is_done;
    int               t;
    logic [WIDTH-1:0] stim;
    logic [CNT_W-1:0] seq;
  } ev_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             mode;
  logic [CNT_W-1:0] repeat_cnt;
  logic             pause;
  logic [WIDTH-1:0] stim;
  logic [CNT_W-1:0] seq;
  logic             stim_valid;
  logic             busy;
  logic             done;

  int  tests_run    = 0;
  int  tests_failed = 0;
  int  cyc          = 0;
  ev_t exp_q[$];

  tb_stim_sequencer #(
    .WIDTH(WIDTH), .HOLD_CYCLES(HOLD), .SEED(SEED), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .repeat_cnt(repeat_cnt),
    .pause     (pause),
    .stim      (stim),
    .seq       (seq),
    .stim_valid(stim_valid),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: cyc holds the number of the most recent rising edge
  always @(posedge clk) cyc++;

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every stim_valid or done pulse must match the next predicted event
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (stim_valid === 1'b1 || done === 1'b1)) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_event", {30'd0, done, stim_valid}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        checkOutput("event_cycle", 32'(cyc), 32'(e.t));
        checkOutput("event_done", 32'(done), 32'(e.is_done));
        checkOutput("event_valid", 32'(stim_valid), 32'(!e.is_done));
        checkOutput("event_stim", 32'(stim), 32'(e.stim));
        checkOutput("event_seq", 32'(seq), 32'(e.seq));
        checkOutput("event_busy", 32'(busy), 32'(!e.is_done));
      end
    end
  end

  // One run: predict events from the spec rules, then drive start/pause edge by edge.
  // pkind: 0 no pause, 1 pause on edges E6..E8, 2 random pause and random stray starts.
  task automatic applyStimulus(input bit m, input int rep, input int pkind,
                               input int restart_off, input int reset_off);
    int          e0, t, cnt, k, v, done_t;
    logic [15:0] l;
    bit          psched[int];
    ev_t         ev;

    @(posedge clk); #1;
    e0 = cyc + 1;

    l = (SEED == 0) ? 16'd1 : 16'(SEED);
    v = m ? int'(l[WIDTH-1:0]) : 0;
    ev.is_done = 1'b0; ev.t = e0; ev.stim = WIDTH'(v); ev.seq = '0;
    exp_q.push_back(ev);
    t = e0; cnt = 0; k = 0; done_t = 0;
    forever begin
      t++;
      if (pkind == 1)      psched[t] = (t >= e0 + 6 && t <= e0 + 8);
      else if (pkind == 2) psched[t] = ($urandom_range(3) == 0);
      else                 psched[t] = 1'b0;
      if (!psched[t]) cnt++;
      if (cnt == HOLD) begin
        cnt = 0;
        if (k < rep) begin
          k++;
          if (m) begin
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            v = int'(l[WIDTH-1:0]);
          end else begin
            v = (v + 1) % (1 << WIDTH);
          end
          ev.is_done = 1'b0; ev.t = t; ev.stim = WIDTH'(v); ev.seq = CNT_W'(k);
          exp_q.push_back(ev);
        end else begin
          ev.is_done = 1'b1; ev.t = t; ev.stim = WIDTH'(v); ev.seq = CNT_W'(k);
          exp_q.push_back(ev);
          done_t = t;
          break;
        end
      end
    end

    start = 1'b1; mode = m; repeat_cnt = CNT_W'(rep); pause = 1'b0;
    while (cyc < done_t) begin
      @(posedge clk); #1;
      if (reset_off != 0 && cyc == e0 + reset_off) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rst_stim", 32'(stim), 32'd0);
        checkOutput("rst_seq", 32'(seq), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_valid", 32'(stim_valid), 32'd0);
        exp_q.delete();
        start = 1'b0; pause = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start = (restart_off != 0 && cyc + 1 == e0 + restart_off) ||
              (pkind == 2 && cyc + 1 < done_t && $urandom_range(7) == 0);
      mode       = 1'($urandom);
      repeat_cnt = CNT_W'($urandom);
      pause      = psched.exists(cyc + 1) ? psched[cyc + 1] : 1'b0;
    end
    start = 1'b0; pause = 1'b0;

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checkOutput("event_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge clk); #1;
    checkOutput("idle_stim_hold", 32'(stim), 32'(v));
    checkOutput("idle_seq_hold", 32'(seq), 32'(k));
    checkOutput("idle_busy", 32'(busy), 32'd0);
  endtask

  // Main sequence: reset state, directed cases from the plan, then randomized runs
  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; repeat_cnt = '0; pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_stim", 32'(stim), 32'd0);
    checkOutput("reset_seq", 32'(seq), 32'd0);
    checkOutput("reset_valid", 32'(stim_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pause = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pause = 1'b0;
    checkOutput("idle_pause_busy", 32'(busy), 32'd0);

    applyStimulus(1'b0, 2,   0, 0, 0);
    applyStimulus(1'b1, 2,   0, 0, 0);
    applyStimulus(1'b0, 0,   0, 0, 0);
    applyStimulus(1'b0, 257, 0, 0, 0);
    applyStimulus(1'b0, 2,   1, 0, 0);
    applyStimulus(1'b0, 3,   0, 4, 0);
    applyStimulus(1'b1, 5,   0, 0, 15);
    applyStimulus(1'b1, 3,   0, 0, 0);
    for (int r = 0; r < 8; r++) begin
      applyStimulus(1'($urandom), int'($urandom_range(6)), 2, 0, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
